v60_regfile_ctrl: RTL and testbench

Owns the single write port and read port 2 of the V60 32x32 register file. It arbitrates write-back between the EX stage, the load-return path and a multi-register transfer sequencer. The sequencer handles PUSHM/POPM/STM/LDM-style register-list operations: it walks a 32-bit register mask and moves one register per handshake to or from the memory unit. It sits between decode/EX/memory and the register file.

---
 rtl/v60_regfile_ctrl.sv | 169 ++++++++++++++++
 tb/tb_v60_regfile_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v60_regfile_ctrl.sv
// V60 register-file write-port arbiter and PUSHM/POPM/STM/LDM register-list sequencer.
// Optional macro V60_REGCTRL_FWD_EN enables EX->store data forwarding.
module v60_regfile_ctrl #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32,
   parameter int AW       = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ex_wen,
   input  logic [AW-1:0]       ex_waddr,
   input  logic [DATA_W-1:0]   ex_wdata,
   input  logic                ld_req,
   input  logic [AW-1:0]       ld_waddr,
   input  logic [DATA_W-1:0]   ld_wdata,
   output logic                ld_ack,
   input  logic [AW-1:0]       dec_raddr2,
   output logic                dec_stall,
   input  logic                mr_start,
   input  logic                mr_dir,
   input  logic                mr_rev,
   input  logic [NUM_REGS-1:0] mr_mask,
   output logic                mr_busy,
   output logic                mr_done,
   output logic [5:0]          mr_count,
   output logic                mem_wvalid,
   output logic [AW-1:0]       mem_wreg,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_wready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_rready,
   output logic [AW-1:0]       rf_raddr2,
   input  logic [DATA_W-1:0]   rf_rdata2,
   output logic [AW-1:0]       rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata,
   output logic                rf_wen
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STORE = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [NUM_REGS-1:0] pend, pend_nxt;
   logic [5:0]          cnt, cnt_nxt;
   logic                rev, rev_nxt;
   logic [AW-1:0]       cur;
   logic [NUM_REGS-1:0] cur_bit;
   logic [NUM_REGS-1:0] pend_clr;
   logic [DATA_W-1:0]   store_data;
   logic                load_beat;

   // Lowest pending register when ascending, highest when descending.
   always_comb begin
      cur = '0;
      if (rev) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (pend[i]) cur = AW'(i);
         end
      end else begin
         for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (pend[i]) cur = AW'(i);
         end
      end
   end

   assign cur_bit  = NUM_REGS'(1) << cur;
   assign pend_clr = pend & ~cur_bit;

`ifdef V60_REGCTRL_FWD_EN
   assign store_data = (ex_wen && (ex_waddr == cur)) ? ex_wdata : rf_rdata2;
`else
   assign store_data = rf_rdata2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
         cnt   <= '0;
         rev   <= 1'b0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
         cnt   <= cnt_nxt;
         rev   <= rev_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pend_nxt   = pend;
      cnt_nxt    = cnt;
      rev_nxt    = rev;
      mr_busy    = (state != IDLE);
      mr_done    = 1'b0;
      dec_stall  = 1'b0;
      rf_raddr2  = dec_raddr2;
      mem_wvalid = 1'b0;
      mem_wreg   = cur;
      mem_wdata  = store_data;
      mem_rready = 1'b0;
      load_beat  = 1'b0;
      case (state)
         IDLE: begin
            if (mr_start) begin
               pend_nxt = mr_mask;
               cnt_nxt  = '0;
               rev_nxt  = mr_rev;
               if (mr_mask == '0) state_nxt = DONE;
               else if (mr_dir)   state_nxt = LOAD;
               else               state_nxt = STORE;
            end
         end
         STORE: begin
            dec_stall  = 1'b1;
            rf_raddr2  = cur;
            mem_wvalid = 1'b1;
            if (mem_wready) begin
               pend_nxt = pend_clr;
               cnt_nxt  = cnt + 6'd1;
               if (pend_clr == '0) state_nxt = DONE;
            end
         end
         LOAD: begin
            // EX owns the write port whenever it fires, so the beat waits.
            mem_rready = !ex_wen;
            if (mem_rvalid && !ex_wen) begin
               load_beat = 1'b1;
               pend_nxt  = pend_clr;
               cnt_nxt   = cnt + 6'd1;
               if (pend_clr == '0) state_nxt = DONE;
            end
         end
         DONE: begin
            mr_done   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mr_count = cnt;

   // Write port: EX, then sequencer load beat, then load return.
   always_comb begin
      rf_wen   = 1'b0;
      rf_waddr = ex_waddr;
      rf_wdata = ex_wdata;
      ld_ack   = 1'b0;
      if (ex_wen) begin
         rf_wen = 1'b1;
      end else if (load_beat) begin
         rf_wen   = 1'b1;
         rf_waddr = cur;
         rf_wdata = mem_rdata;
      end else if (ld_req) begin
         rf_wen   = 1'b1;
         rf_waddr = ld_waddr;
         rf_wdata = ld_wdata;
         ld_ack   = 1'b1;
      end
   end

endmodule

// File: tb/tb_v60_regfile_ctrl.sv
// Self-checking bench for v60_regfile_ctrl: regfile model, register-list reference
// queues built from the mask, and directed plus randomized sequencer operations.
module tb_v60_regfile_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ex_wen;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic        ld_req;
   logic [4:0]  ld_waddr;
   logic [31:0] ld_wdata;
   logic        ld_ack;
   logic [4:0]  dec_raddr2;
   logic        dec_stall;
   logic        mr_start;
   logic        mr_dir;
   logic        mr_rev;
   logic [31:0] mr_mask;
   logic        mr_busy;
   logic        mr_done;
   logic [5:0]  mr_count;
   logic        mem_wvalid;
   logic [4:0]  mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_wready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_rready;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata2;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rf_wen;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_rf [32];
   logic [31:0] rf_mem [32];

   v60_regfile_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .ld_req(ld_req), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
      .dec_raddr2(dec_raddr2), .dec_stall(dec_stall),
      .mr_start(mr_start), .mr_dir(mr_dir), .mr_rev(mr_rev), .mr_mask(mr_mask),
      .mr_busy(mr_busy), .mr_done(mr_done), .mr_count(mr_count),
      .mem_wvalid(mem_wvalid), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_wready(mem_wready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_rready(mem_rready),
      .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen)
   );

   // Register file: combinational read port 2, write commits on the clock edge.
   always @(posedge clk) begin
      if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
   end
   assign rf_rdata2 = rf_mem[rf_raddr2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic build_order(input logic [31:0] mask, input logic rev, output int q[$]);
      q = {};
      for (int i = 0; i < 32; i++) begin
         if (rev) begin
            if (mask[31-i]) q.push_back(31 - i);
         end else begin
            if (mask[i]) q.push_back(i);
         end
      end
   endtask

   task automatic ex_write(input logic [4:0] a, input logic [31:0] d);
      ex_wen = 1'b1; ex_waddr = a; ex_wdata = d;
      next_cycle();
      ex_wen = 1'b0;
      exp_rf[a] = d;
   endtask

   task automatic check_rf(input string tag);
      for (int i = 0; i < 32; i++) begin
         dec_raddr2 = 5'(i);
         #1;
         check({tag, "_rd"}, rf_rdata2, exp_rf[i]);
      end
      check({tag, "_stall"}, {31'd0, dec_stall}, 32'd0);
      next_cycle();
   endtask

   task automatic run_store(input logic [31:0] mask, input logic rev, input int ready_pct,
                            output int stall_cycles);
      int q[$];
      int exp_n;
      int guard;
      bit fin;
      build_order(mask, rev, q);
      exp_n = q.size();
      mr_start = 1'b1; mr_dir = 1'b0; mr_rev = rev; mr_mask = mask;
      #2;
      check("st_start_busy", {31'd0, mr_busy}, 32'd0);
      next_cycle();
      stall_cycles = 0; fin = 1'b0; guard = 0;
      while (!fin && guard < 400) begin
         mr_start   = ($urandom_range(0, 7) == 0);
         mr_dir     = 1'($urandom);
         mr_rev     = ~rev;
         mr_mask    = $urandom;
         mem_wready = ($urandom_range(0, 99) < ready_pct);
         #2;
         stall_cycles += int'(dec_stall);
         check("st_busy", {31'd0, mr_busy}, 32'd1);
         if (q.size() != 0) begin
            check("st_wvalid", {31'd0, mem_wvalid}, 32'd1);
            check("st_wreg", {27'd0, mem_wreg}, q[0]);
            check("st_wdata", mem_wdata, exp_rf[q[0]]);
            check("st_stall", {31'd0, dec_stall}, 32'd1);
            check("st_raddr2", {27'd0, rf_raddr2}, q[0]);
            check("st_done_early", {31'd0, mr_done}, 32'd0);
            if (mem_wready) void'(q.pop_front());
         end else begin
            check("st_done", {31'd0, mr_done}, 32'd1);
            check("st_count", {26'd0, mr_count}, exp_n);
            check("st_wvalid_done", {31'd0, mem_wvalid}, 32'd0);
            fin = 1'b1;
         end
         next_cycle();
         guard++;
      end
      mr_start = 1'b0; mem_wready = 1'b0;
      check("st_finished", {31'd0, fin}, 32'd1);
      #2;
      check("st_idle", {31'd0, mr_busy}, 32'd0);
      check("st_done_once", {31'd0, mr_done}, 32'd0);
      next_cycle();
   endtask

   task automatic run_load(input logic [31:0] mask, input logic rev, input int valid_pct,
                           input int ex_at, input bit seq_data);
      int q[$];
      int exp_n;
      int guard;
      int beat_idx;
      bit fin;
      build_order(mask, rev, q);
      exp_n = q.size();
      mr_start = 1'b1; mr_dir = 1'b1; mr_rev = rev; mr_mask = mask;
      next_cycle();
      mr_start = 1'b0; mr_rev = ~rev;
      fin = 1'b0; guard = 0; beat_idx = 0;
      while (!fin && guard < 400) begin
         ex_wen = (ex_at >= 0) && (guard == ex_at || guard == ex_at + 1);
         ex_waddr = 5'($urandom_range(0, 31));
         ex_wdata = $urandom;
         mem_rvalid = ($urandom_range(0, 99) < valid_pct);
         mem_rdata = seq_data ? 32'hA + 32'(beat_idx) : $urandom;
         #2;
         check("ld_stall", {31'd0, dec_stall}, 32'd0);
         if (ex_wen) begin
            check("ld_ex_wen", {31'd0, rf_wen}, 32'd1);
            check("ld_ex_waddr", {27'd0, rf_waddr}, {27'd0, ex_waddr});
            check("ld_ex_wdata", rf_wdata, ex_wdata);
            exp_rf[ex_waddr] = ex_wdata;
         end
         if (q.size() != 0) begin
            check("ld_rready", {31'd0, mem_rready}, {31'd0, !ex_wen});
            check("ld_done_early", {31'd0, mr_done}, 32'd0);
            if (!ex_wen && mem_rvalid) begin
               check("ld_beat_wen", {31'd0, rf_wen}, 32'd1);
               check("ld_beat_waddr", {27'd0, rf_waddr}, q[0]);
               check("ld_beat_wdata", rf_wdata, mem_rdata);
               exp_rf[q[0]] = mem_rdata;
               void'(q.pop_front());
               beat_idx++;
            end else if (!ex_wen) begin
               check("ld_idle_wen", {31'd0, rf_wen}, 32'd0);
            end
         end else begin
            check("ld_done", {31'd0, mr_done}, 32'd1);
            check("ld_count", {26'd0, mr_count}, exp_n);
            check("ld_rready_done", {31'd0, mem_rready}, 32'd0);
            fin = 1'b1;
         end
         next_cycle();
         guard++;
      end
      ex_wen = 1'b0; mem_rvalid = 1'b0;
      check("ld_finished", {31'd0, fin}, 32'd1);
   endtask

   initial begin
      int stalls;
      logic [31:0] old_v;
      logic [31:0] new_v;
      logic [31:0] d1;
      logic [31:0] d2;
      rst_n = 1'b0;
      ex_wen = 1'b0; ex_waddr = '0; ex_wdata = '0;
      ld_req = 1'b0; ld_waddr = '0; ld_wdata = '0;
      dec_raddr2 = '0;
      mr_start = 1'b0; mr_dir = 1'b0; mr_rev = 1'b0; mr_mask = '0;
      mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #3;
      check("rst_busy", {31'd0, mr_busy}, 32'd0);
      check("rst_done", {31'd0, mr_done}, 32'd0);
      check("rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
      check("rst_rready", {31'd0, mem_rready}, 32'd0);
      check("rst_stall", {31'd0, dec_stall}, 32'd0);
      check("rst_wen", {31'd0, rf_wen}, 32'd0);
      check("rst_count", {26'd0, mr_count}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      next_cycle();

      for (int i = 0; i < 32; i++) ex_write(5'(i), $urandom);
      ex_write(5'd0, 32'h11);
      ex_write(5'd2, 32'h22);
      check_rf("preload");

      // Two-register ascending store, memory always ready.
      run_store(32'h0000_0005, 1'b0, 100, stalls);
      check("st5_stall_cycles", stalls, 32'd2);

      // Descending load of R31 then R0.
      run_load(32'h8000_0001, 1'b1, 100, -1, 1'b1);
      dec_raddr2 = 5'd31; #1;
      check("ld_r31", rf_rdata2, 32'hA);
      dec_raddr2 = 5'd0; #1;
      check("ld_r0", rf_rdata2, 32'hB);
      next_cycle();

      // Load interrupted by two EX write-backs.
      run_load($urandom | 32'h0F0F_0000, 1'($urandom), 100, 2, 1'b0);
      check_rf("ld_ex");

      // Load-return and EX to the same register in one cycle.
      d1 = $urandom; d2 = $urandom;
      ex_wen = 1'b1; ex_waddr = 5'd5; ex_wdata = d1;
      ld_req = 1'b1; ld_waddr = 5'd5; ld_wdata = d2;
      #2;
      check("coll_ack0", {31'd0, ld_ack}, 32'd0);
      check("coll_wdata_ex", rf_wdata, d1);
      next_cycle();
      ex_wen = 1'b0;
      #2;
      check("coll_ack1", {31'd0, ld_ack}, 32'd1);
      check("coll_waddr_ld", {27'd0, rf_waddr}, 32'd5);
      check("coll_wdata_ld", rf_wdata, d2);
      next_cycle();
      ld_req = 1'b0;
      exp_rf[5] = d2;
      check_rf("coll");

      run_store(32'h0, 1'($urandom), 100, stalls);
      check("st0_stall_cycles", stalls, 32'd0);
      run_store(32'hFFFF_FFFF, 1'($urandom), 100, stalls);
      check("stfull_stall_cycles", stalls, 32'd32);

      // Reset in the middle of a store after three accepted beats.
      mr_start = 1'b1; mr_dir = 1'b0; mr_rev = 1'b0; mr_mask = 32'h0000_00FF;
      next_cycle();
      mr_start = 1'b0; mem_wready = 1'b1;
      repeat (3) next_cycle();
      #1;
      check("rst_mid_wreg", {27'd0, mem_wreg}, 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", {31'd0, mr_busy}, 32'd0);
      check("rst_mid_wvalid", {31'd0, mem_wvalid}, 32'd0);
      check("rst_mid_stall", {31'd0, dec_stall}, 32'd0);
      check("rst_mid_count", {26'd0, mr_count}, 32'd0);
      mem_wready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         #2;
         check("rst_mid_nodone", {31'd0, mr_done}, 32'd0);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      run_store($urandom, 1'($urandom), 60, stalls);

      // EX write to the register currently being stored.
      old_v = exp_rf[7]; new_v = ~old_v;
      mr_start = 1'b1; mr_dir = 1'b0; mr_rev = 1'b0; mr_mask = 32'h0000_0080;
      next_cycle();
      mr_start = 1'b0; mem_wready = 1'b0;
      ex_wen = 1'b1; ex_waddr = 5'd7; ex_wdata = new_v;
      #2;
`ifdef V60_REGCTRL_FWD_EN
      check("fwd_wdata", mem_wdata, new_v);
`else
      check("nofwd_wdata", mem_wdata, old_v);
`endif
      next_cycle();
      ex_wen = 1'b0; mem_wready = 1'b1;
      exp_rf[7] = new_v;
      #2;
      check("fwd_after_commit", mem_wdata, new_v);
      next_cycle();
      mem_wready = 1'b0;
      #2;
      check("fwd_done", {31'd0, mr_done}, 32'd1);
      check("fwd_count", {26'd0, mr_count}, 32'd1);
      next_cycle();

      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 1) == 1)
            run_load($urandom & $urandom, 1'($urandom), $urandom_range(30, 100),
                     $urandom_range(0, 4), 1'b0);
         else
            run_store($urandom & $urandom, 1'($urandom), $urandom_range(30, 100), stalls);
      end
      check_rf("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
